// File: rtl/module_keypad_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the 4x4 keypad scanner.
package module_keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } scan_state_t;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } one_cold_t;

  // Index of the single low bit; valid is clear for zero or multiple low bits.
  function automatic one_cold_t one_cold_idx(input logic [3:0] v);
    one_cold_t r;
    r = '0;
    case (v)
      4'b1110: r = '{valid: 1'b1, idx: 2'd0};
      4'b1101: r = '{valid: 1'b1, idx: 2'd1};
      4'b1011: r = '{valid: 1'b1, idx: 2'd2};
      4'b0111: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/module_sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer with async active-low reset and a configurable reset value.
module module_sync_2ff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/module_keypad_scanner.sv
`timescale 1ns/1ps
// 4x4 keypad scan controller: rotates column drive, samples rows, and debounces
// press/release of the whole matrix on one shared counter.
module module_keypad_scanner
  import module_keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 50_000,
  parameter int unsigned DEBOUNCE_TICKS = 500_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row_i,
  output logic [NUM_COLS-1:0] col_o,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int unsigned MAX_TICKS = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [NUM_ROWS-1:0] rows_s;

  module_sync_2ff #(
    .WIDTH       (NUM_ROWS),
    .RESET_VALUE (4'hF)
  ) u_row_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (row_i),
    .q_o   (rows_s)
  );

  scan_state_t         state_q,     state_d;
  logic [1:0]          col_idx_q,   col_idx_d;
  logic [1:0]          row_idx_q,   row_idx_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [NUM_COLS-1:0] col_o_q,     col_o_d;
  key_code_t           key_code_q,  key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q,  key_held_d;

  one_cold_t           hit;
  logic [NUM_ROWS-1:0] row_pat;

  assign hit     = one_cold_idx(rows_s);
  assign row_pat = ~(4'b0001 << row_idx_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SCAN;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      cnt_q       <= '0;
      col_o_q     <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      col_o_q     <= col_o_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (hit.valid) begin
            row_idx_d = hit.idx;
            state_d   = DEBOUNCE;
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (rows_s != row_pat) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
          state_d   = SCAN;
        end else if (cnt_q == DEB_LAST) begin
          key_code_d  = {row_idx_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          cnt_d       = '0;
          state_d     = PRESSED;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Any pattern other than all-high, even another key in this column, keeps the hold.
      PRESSED: begin
        cnt_d = '0;
        if (rows_s == '1) state_d = RELEASE;
      end

      RELEASE: begin
        if (rows_s != '1) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_q == DEB_LAST) begin
          key_held_d = 1'b0;
          cnt_d      = '0;
          col_idx_d  = col_idx_q + 2'd1;
          state_d    = SCAN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: state_d = SCAN;
    endcase

    col_o_d = ~(4'b0001 << col_idx_d);
  end

  assign col_o     = col_o_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: doc/module_keypad_scanner.md
# module_keypad_scanner

Scan controller for the 4x4 matrix keypad. It drives the columns one at a time and samples the rows. It runs the debounce counting for the whole matrix on one shared counter, replacing one debouncer per key. The result is a single registered key code with a one-cycle valid strobe for downstream logic.

## Interface

- SCAN_TICKS, default 50_000: clock cycles each column is driven before its rows are sampled; must be >= 4.
- DEBOUNCE_TICKS, default 500_000: consecutive stable cycles required to accept a press or a release; must be >= 2.
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- row_i  input  4  keypad rows, asynchronous, active-low (pulled up externally).
- col_o  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  accepted key, {row_idx[1:0], col_idx[1:0]}; holds its value until the next accepted press.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from the key_valid cycle until the release is accepted.

## Operation

- row_i passes through a 2-FF synchronizer (reset value 4'hF) and is used as rows_s.
- Shared counter cnt, width $clog2(max(SCAN_TICKS, DEBOUNCE_TICKS)+1).
- Column index col_idx is 2 bits and wraps 3 -> 0.
- SCAN:
  - Drive col_o = ~(1 << col_idx); cnt counts 0..SCAN_TICKS-1.
  - On the cycle cnt == SCAN_TICKS-1, sample rows_s and clear cnt.
  - If exactly one bit of rows_s is low: latch row_idx and col_idx, then go to DEBOUNCE.
  - Otherwise (no row low, or more than one): increment col_idx and stay in SCAN.
- DEBOUNCE:
  - Column stays held. Each cycle, compare rows_s with the latched one-cold pattern.
  - Mismatch: clear cnt, increment col_idx, go to SCAN.
  - Match with cnt == DEBOUNCE_TICKS-1: update key_code, pulse key_valid, set key_held, clear cnt, go to PRESSED.
- PRESSED:
  - Column stays held and cnt stays at 0.
  - rows_s == 4'hF: go to RELEASE.
  - Any other pattern, including a second key in the same column: stay.
- RELEASE:
  - rows_s == 4'hF for DEBOUNCE_TICKS consecutive cycles: clear key_held, clear cnt, increment col_idx, go to SCAN.
  - Any low bit: clear cnt, go back to PRESSED; key_held stays high and key_valid does not fire.
- A second key in a different column is invisible while a key is held. Scanning resumes only after the release is accepted.

## Timing

- Reset values (asserted asynchronously):
  - state SCAN, col_idx 0, cnt 0.
  - col_o 4'b1110, key_code 4'h0, key_valid 0, key_held 0.
  - Synchronizer flops 4'hF.
- All outputs are registered; no combinational path from row_i to any output.
- Sampling at the end of the dwell leaves SCAN_TICKS-2 cycles for the column to settle, after the 2-cycle synchronizer delay.
- Press latency, from the first synchronized stable low at the sampled cycle of the matching column: key_valid rises DEBOUNCE_TICKS cycles later.
- Release latency: key_held falls DEBOUNCE_TICKS cycles after rows_s first reads 4'hF.
- key_valid fires exactly once per accepted press and is never high for two consecutive cycles.
- If reset deasserts mid-press, the key is detected fresh from SCAN column 0.

## Structure

- Package module_keypad_pkg:
  - NUM_ROWS = 4, NUM_COLS = 4.
  - State enum scan_state_t {SCAN, DEBOUNCE, PRESSED, RELEASE}.
  - key_code_t = logic [3:0].
  - Helper function one_cold_idx (4-bit one-cold vector -> 2-bit index plus a valid flag).
- Sub-module module_sync_2ff: parameterized width, async active-low reset, reset value parameter; instantiated with width 4 and reset value 4'hF.
- Everything else (FSM, counter, column rotation, output registers) lives in the top module.

## Test plan

Bench parameters: SCAN_TICKS=4, DEBOUNCE_TICKS=8, clock period 20 ns.

1. Reset and idle: hold rst low, then release with no key pressed.
   - Outputs at reset values; col_o steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, one step every 4 cycles.
   - key_valid never asserts.
2. Clean press: model key row 2 / col 1 (row_i[2] low while col_o[1] low), hold 50 cycles, then release.
   - One key_valid pulse with key_code 4'h9.
   - key_held high until 8 cycles after the synchronized release.
3. Bounce: toggle row_i[2] every 3 cycles for 30 cycles, then hold it low.
   - No key_valid during the bounce; exactly one key_valid after 8 stable cycles.
4. Release bounce: while key_held is high, release for 4 cycles and press again, then release cleanly.
   - key_held stays high through the glitch; no second key_valid; one key_held fall.
5. Multi-key: press rows 0 and 3 in column 2 together; then press col 0 row 0 while col 3 row 3 is held.
   - Multi-row case: no key_valid.
   - Cross-column case: only the first accepted key is reported; a key_valid for the other key comes only after the first is released.
6. Reset mid-DEBOUNCE: assert rst during DEBOUNCE.
   - Outputs return to reset values immediately.
   - After rst releases with the key still held, key_valid fires only after the full scan plus debounce sequence.
